// File: rtl/ddr2_rbuf_pkg.sv
// Shared types and sizing helpers for the DDR2 read-data ring buffer.
package ddr2_rbuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_CAPT  = 2'd2,
    ST_DROP  = 2'd3
  } rbuf_state_t;

  localparam int DEF_DW      = 16;
  localparam int DEF_BL      = 8;
  localparam int DEF_NBURST  = 4;
  localparam int DEF_TIMEOUT = 15;

  // Bit n set means burst length n is supported (4 and 8).
  localparam logic [31:0] BL_LEGAL_MASK = 32'h0000_0110;

  function automatic bit bl_legal(input int bl);
    if ((bl > 0) && (bl < 32)) return BL_LEGAL_MASK[bl[4:0]];
    else return 1'b0;
  endfunction

  function automatic int ring_words(input int nburst, input int bl);
    return nburst * bl;
  endfunction

  function automatic int word_ptr_w(input int nburst, input int bl);
    return $clog2(nburst * bl);
  endfunction

  function automatic int count_w(input int nburst, input int bl);
    return $clog2(nburst * bl) + 1;
  endfunction

endpackage

// File: rtl/ddr2_rbuf_mem.sv
// Ring storage for the DDR2 read buffer: 1-write/1-read register array, combinational read.
module ddr2_rbuf_mem
  import ddr2_rbuf_pkg::*;
#(
  parameter int W     = 2 * DEF_DW,
  parameter int DEPTH = DEF_NBURST * DEF_BL / 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Data array write port, deliberately without reset
  always_ff @(posedge clk) begin
    if (we) mem_r[waddr] <= wdata;
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/ddr2_read_ring_buffer.sv
// DDR2 read-data ring buffer: listen-armed burst capture, whole-burst commit, word-wise pop.
// Optional statistics counters are enabled by defining DDR2_RBUF_STATS_EN.
module ddr2_read_ring_buffer
  import ddr2_rbuf_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int BL      = DEF_BL,
  parameter int NBURST  = DEF_NBURST,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          listen,
  input  logic          beat_valid,
  input  logic [DW-1:0] din_rise,
  input  logic [DW-1:0] din_fall,
  input  logic          rd_en,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          empty,
  output logic          full,
  output logic          burst_done,
  output logic          overflow,
  output logic          timeout_err,
  input  logic          clear_err,
  output logic [15:0]   stat_bursts,
  output logic [15:0]   stat_drops
);

  // An unsupported burst length falls back to the default rather than corrupting sizing.
  localparam int BL_EFF = bl_legal(BL) ? BL : DEF_BL;
  localparam int HALF   = BL_EFF / 2;
  localparam int RING   = ring_words(NBURST, BL_EFF);
  localparam int DEPTH  = RING / 2;
  localparam int RW     = word_ptr_w(NBURST, BL_EFF);
  localparam int PW     = RW - 1;
  localparam int CW     = count_w(NBURST, BL_EFF);
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int BW     = $clog2(HALF);

  rbuf_state_t   state_r, state_nxt_s;
  logic [TW-1:0] timer_r, timer_nxt_s;
  logic [BW-1:0] beat_r, beat_nxt_s;
  logic [PW-1:0] wr_shadow_r, wr_commit_r;
  logic [RW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r, free_s;
  logic [DW-1:0] dout_r, rd_word_s;
  logic [2*DW-1:0] mem_rdata_s;
  logic dout_valid_r, burst_done_r, overflow_r, timeout_err_r;
  logic wr_en_s, commit_s, abort_s, ovf_set_s, pop_s, space_s, expired_s, last_beat_s;

  assign free_s      = CW'(RING) - count_r;
  assign space_s     = (free_s >= CW'(BL_EFF));
  assign pop_s       = rd_en && (count_r != CW'(0));
  assign expired_s   = (timer_r == TW'(TIMEOUT - 1));
  assign last_beat_s = (beat_r == BW'(HALF - 1));
  assign rd_word_s   = rd_ptr_r[0] ? mem_rdata_s[2*DW-1:DW] : mem_rdata_s[DW-1:0];

  ddr2_rbuf_mem #(.W(2 * DW), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (wr_en_s),
    .waddr (wr_shadow_r),
    .wdata ({din_fall, din_rise}),
    .raddr (rd_ptr_r[RW-1:1]),
    .rdata (mem_rdata_s)
  );

  // Burst capture FSM: next state, timer, beat count and write/commit strobes
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    beat_nxt_s  = beat_r;
    wr_en_s     = 1'b0;
    commit_s    = 1'b0;
    abort_s     = 1'b0;
    ovf_set_s   = listen && (state_r != ST_IDLE);
    case (state_r)
      ST_IDLE: begin
        timer_nxt_s = TW'(0);
        beat_nxt_s  = BW'(0);
        if (listen && space_s) begin
          state_nxt_s = ST_ARMED;
        end else if (listen) begin
          state_nxt_s = ST_DROP;
          ovf_set_s   = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (beat_valid) begin
          wr_en_s     = 1'b1;
          beat_nxt_s  = BW'(1);
          timer_nxt_s = TW'(0);
          state_nxt_s = ST_CAPT;
        end else if (expired_s) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          timer_nxt_s = timer_r + TW'(1);
        end
      end
      ST_CAPT: begin
        if (beat_valid) begin
          wr_en_s     = 1'b1;
          timer_nxt_s = TW'(0);
          if (last_beat_s) begin
            commit_s    = 1'b1;
            beat_nxt_s  = BW'(0);
            state_nxt_s = ST_IDLE;
          end else begin
            beat_nxt_s = beat_r + BW'(1);
          end
        end else if (expired_s) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          timer_nxt_s = timer_r + TW'(1);
        end
      end
      ST_DROP: begin
        if (beat_valid) begin
          timer_nxt_s = TW'(0);
          if (last_beat_s) begin
            state_nxt_s = ST_IDLE;
          end else begin
            beat_nxt_s = beat_r + BW'(1);
          end
        end else if (expired_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          timer_nxt_s = timer_r + TW'(1);
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state, ring pointers and committed-word count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      timer_r     <= TW'(0);
      beat_r      <= BW'(0);
      wr_shadow_r <= PW'(0);
      wr_commit_r <= PW'(0);
      rd_ptr_r    <= RW'(0);
      count_r     <= CW'(0);
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
      beat_r  <= beat_nxt_s;
      // An aborted burst rewinds so its partial beats are simply overwritten later.
      if (abort_s) wr_shadow_r <= wr_commit_r;
      else if (wr_en_s) wr_shadow_r <= wr_shadow_r + PW'(1);
      if (commit_s) wr_commit_r <= wr_shadow_r + PW'(1);
      if (pop_s) rd_ptr_r <= rd_ptr_r + RW'(1);
      count_r <= count_r + (commit_s ? CW'(BL_EFF) : CW'(0)) - (pop_s ? CW'(1) : CW'(0));
    end
  end

  // Registered read port, commit pulse and sticky error flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_r        <= DW'(0);
      dout_valid_r  <= 1'b0;
      burst_done_r  <= 1'b0;
      overflow_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      dout_valid_r <= pop_s;
      if (pop_s) dout_r <= rd_word_s;
      burst_done_r <= commit_s;
      if (clear_err) overflow_r <= 1'b0;
      else if (ovf_set_s) overflow_r <= 1'b1;
      if (clear_err) timeout_err_r <= 1'b0;
      else if (abort_s) timeout_err_r <= 1'b1;
    end
  end

  assign dout        = dout_r;
  assign dout_valid  = dout_valid_r;
  assign burst_done  = burst_done_r;
  assign overflow    = overflow_r;
  assign timeout_err = timeout_err_r;
  assign empty       = (count_r == CW'(0));
  assign full        = !space_s;

`ifdef DDR2_RBUF_STATS_EN
  logic [15:0] stat_bursts_r, stat_drops_r;
  logic        drop_evt_s;

  assign drop_evt_s = abort_s || ((state_r == ST_IDLE) && (state_nxt_s == ST_DROP));

  // Saturating commit and drop counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_bursts_r <= 16'h0000;
      stat_drops_r  <= 16'h0000;
    end else begin
      if (commit_s && (stat_bursts_r != 16'hFFFF)) stat_bursts_r <= stat_bursts_r + 16'h0001;
      if (drop_evt_s && (stat_drops_r != 16'hFFFF)) stat_drops_r <= stat_drops_r + 16'h0001;
    end
  end

  assign stat_bursts = stat_bursts_r;
  assign stat_drops  = stat_drops_r;
`else
  assign stat_bursts = 16'h0000;
  assign stat_drops  = 16'h0000;
`endif

endmodule

// File: tb/tb_ddr2_read_ring_buffer.sv
// Directed bench for ddr2_read_ring_buffer (BL=8, NBURST=4, TIMEOUT=15): vector table plus
// queue-modelled sequences for full/drop, timeout, wrap with concurrent pops and mid-burst reset.
module tb_ddr2_read_ring_buffer;

  logic        clk = 1'b0;
  logic        reset_n, listen, beat_valid, rd_en, clear_err;
  logic [15:0] din_rise, din_fall, dout, stat_bursts, stat_drops;
  logic        dout_valid, empty, full, burst_done, overflow, timeout_err;

  int total = 0;
  int bad   = 0;
  logic [15:0] mq[$];
  logic [15:0] pend[$];

  typedef struct {
    logic        lis, bv, rd, clr;
    logic [15:0] r, f;
    logic [21:0] exp;  // {dout_valid, dout, empty, full, burst_done, overflow, timeout_err}
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  ddr2_read_ring_buffer dut (
    .clk(clk), .reset_n(reset_n), .listen(listen), .beat_valid(beat_valid),
    .din_rise(din_rise), .din_fall(din_fall), .rd_en(rd_en), .dout(dout),
    .dout_valid(dout_valid), .empty(empty), .full(full), .burst_done(burst_done),
    .overflow(overflow), .timeout_err(timeout_err), .clear_err(clear_err),
    .stat_bursts(stat_bursts), .stat_drops(stat_drops)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic lis, input logic bv, input logic [15:0] r,
                              input logic [15:0] f, input logic rd, input logic clr,
                              input logic dv, input logic [15:0] d, input logic emp,
                              input logic bd, input logic ovf);
    vec_t v;
    v.lis = lis; v.bv = bv; v.r = r; v.f = f; v.rd = rd; v.clr = clr;
    v.exp = {dv, d, emp, 1'b0, bd, ovf, 1'b0};
    return v;
  endfunction

  // One clock with the given inputs; pops and commits are tracked in the word queue model.
  task automatic cyc(input logic lis, input logic bv, input logic [15:0] r, input logic [15:0] f,
                     input logic rd, input logic commit);
    bit exp_pop;
    exp_pop = rd && (mq.size() != 0);
    listen = lis; beat_valid = bv; din_rise = r; din_fall = f; rd_en = rd;
    @(posedge clk); #1;
    listen = 1'b0; beat_valid = 1'b0; rd_en = 1'b0;
    check("dout_valid", dout_valid, exp_pop);
    if (exp_pop) check("dout", dout, mq.pop_front());
    if (commit) while (pend.size() != 0) mq.push_back(pend.pop_front());
    check("burst_done", burst_done, commit);
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() > 24);
  endtask

  task automatic send_burst(input logic [15:0] base, input logic rd, input bit accepted);
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000, rd, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (accepted) begin
        pend.push_back(base + 16'(2 * i));
        pend.push_back(base + 16'(2 * i + 1));
      end
      cyc(1'b0, 1'b1, base + 16'(2 * i), base + 16'(2 * i + 1), rd, accepted && (i == 3));
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clk); #1;
    clear_err = 1'b0;
  endtask

  initial begin
    logic [21:0] got;
    reset_n = 1'b0; listen = 1'b0; beat_valid = 1'b0; rd_en = 1'b0; clear_err = 1'b0;
    din_rise = 16'h0000; din_fall = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;

    check("rst_dout", dout, 16'h0000);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_burst_done", burst_done, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_timeout_err", timeout_err, 1'b0);
    check("rst_stat_bursts", stat_bursts, 16'h0000);
    check("rst_stat_drops", stat_drops, 16'h0000);

    // Basic burst, ordered pops, empty-pop, listen+beat same cycle, listen during CAPT, clear_err
    tbl.push_back(mk(1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0000, 16'h0001, 0, 0, 0, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0002, 16'h0003, 0, 0, 0, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0004, 16'h0005, 0, 0, 0, 16'h0000, 1, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0006, 16'h0007, 0, 0, 0, 16'h0000, 0, 1, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'(i), (i == 7), 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0007, 1, 0, 0));
    tbl.push_back(mk(1, 1, 16'h00AA, 16'h00BB, 0, 0, 0, 16'h0007, 1, 0, 0));
    tbl.push_back(mk(0, 1, 16'h0010, 16'h0011, 0, 0, 0, 16'h0007, 1, 0, 0));
    tbl.push_back(mk(1, 1, 16'h0012, 16'h0013, 0, 0, 0, 16'h0007, 1, 0, 1));
    tbl.push_back(mk(0, 1, 16'h0014, 16'h0015, 0, 0, 0, 16'h0007, 1, 0, 1));
    tbl.push_back(mk(0, 1, 16'h0016, 16'h0017, 0, 0, 0, 16'h0007, 0, 1, 1));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 1, 0, 16'h0007, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h0010 + 16'(i), (i == 7), 0, 0));
    tbl.push_back(mk(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0017, 1, 0, 0));

    foreach (tbl[i]) begin
      listen = tbl[i].lis; beat_valid = tbl[i].bv; din_rise = tbl[i].r; din_fall = tbl[i].f;
      rd_en = tbl[i].rd; clear_err = tbl[i].clr;
      @(posedge clk); #1;
      got = {dout_valid, dout, empty, full, burst_done, overflow, timeout_err};
      total++;
      if (got !== tbl[i].exp) begin
        bad++;
        $display("FAIL vec%0d got=%h exp=%h", i, got, tbl[i].exp);
      end
    end
    listen = 1'b0; beat_valid = 1'b0; rd_en = 1'b0; clear_err = 1'b0;

    // Fill the ring, drop a fifth burst, free one burst slot and commit again
    for (int b = 0; b < 4; b++) send_burst(16'h0100 * 16'(b + 1), 1'b0, 1'b1);
    check("full_after_4", full, 1'b1);
    send_burst(16'hDD00, 1'b0, 1'b0);
    check("overflow_on_drop", overflow, 1'b1);
    pulse_clear();
    check("overflow_cleared", overflow, 1'b0);
    drain(8);
    send_burst(16'h0500, 1'b0, 1'b1);
    drain(32);

    // Timeout mid-burst, then timeout while armed; the next burst reads back clean
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'hEE00, 16'hEE01, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'hEE02, 16'hEE03, 1'b0, 1'b0);
    idle(14);
    check("capt_tmo_early", timeout_err, 1'b0);
    idle(1);
    check("capt_tmo", timeout_err, 1'b1);
    pulse_clear();
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    idle(14);
    check("armed_tmo_early", timeout_err, 1'b0);
    idle(1);
    check("armed_tmo", timeout_err, 1'b1);
    pulse_clear();
    check("tmo_cleared", timeout_err, 1'b0);
    send_burst(16'h0700, 1'b0, 1'b1);
    drain(8);

    // Ten bursts with a pop every cycle: commit+pop overlap and pointer wrap
    for (int b = 0; b < 10; b++) begin
      send_burst(16'h1000 + 16'(b * 16), 1'b1, 1'b1);
      drain(3);
    end
    drain(mq.size());

    // Asynchronous reset in the middle of a capture
    send_burst(16'h2000, 1'b0, 1'b1);
    drain(1);
    cyc(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 16'h2100, 16'h2101, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'h2102, 16'h2103, 1'b0, 1'b0);
    check("pre_rst_overflow", overflow, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_dout", dout, 16'h0000);
    check("midrst_dout_valid", dout_valid, 1'b0);
    check("midrst_empty", empty, 1'b1);
    check("midrst_full", full, 1'b0);
    check("midrst_burst_done", burst_done, 1'b0);
    check("midrst_overflow", overflow, 1'b0);
    check("midrst_timeout_err", timeout_err, 1'b0);
    mq.delete();
    pend.delete();
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    send_burst(16'h3000, 1'b0, 1'b1);
    drain(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr2_read_ring_buffer.md
Name: ddr2_read_ring_buffer

Overview:
Parametrised, single-clock successor to the DDR2 read-data ring buffer. It accepts deserialised rise/fall data pairs from the read capture front end after a one-cycle listen pulse. Each burst is collected into a multi-burst ring, and a burst is committed only once it is complete. Sits between the DQ/DQS capture stage and the controller read-return path; adds burst-length selection, multi-burst depth, flow control, timeout and overflow handling.

Parameters:
DW, 16, data width per word (DQ width)
BL, 8, burst length in words; legal values 4 or 8
NBURST, 4, bursts held in ring; power of 2, >=2
TIMEOUT, 15, max idle clk cycles while waiting for or between beats; >=1

Ports:
clk  in  1  system clock; all logic on posedge
reset_n  in  1  asynchronous, active-low reset
listen  in  1  one-cycle pulse; arms capture of one burst
beat_valid  in  1  din_rise/din_fall carry one beat (two words) this cycle
din_rise  in  DW  word captured on DQS rising edge (even word)
din_fall  in  DW  word captured on DQS falling edge (odd word)
rd_en  in  1  pop one committed word
dout  out  DW  popped word, registered
dout_valid  out  1  dout updated this cycle
empty  out  1  no committed words
full  out  1  free space < BL words
burst_done  out  1  one-cycle pulse when a burst commits
overflow  out  1  sticky: burst dropped for lack of space, or listen while busy
timeout_err  out  1  sticky: burst aborted by timeout
clear_err  in  1  clears overflow and timeout_err
stat_bursts  out  16  committed-burst counter (optional feature)
stat_drops  out  16  dropped/aborted-burst counter (optional feature)

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; all pointers and counters 0; dout=0; dout_valid=0; empty=1; full=0; burst_done=0; overflow=0; timeout_err=0; stat_* = 0.
- Storage: NBURST*BL/2 entries, each 2*DW wide {fall,rise}. Read side pops rise (even) first, then fall (odd). Word order is identical to legacy r0..r7.
- FSM states:
  - IDLE: listen & free>=BL -> ARMED, timer=0. listen & free<BL -> DROP, overflow=1. beat_valid is ignored.
  - ARMED: beat_valid -> write beat at shadow write pointer, beat_cnt=1, -> CAPT. No beat for TIMEOUT cycles -> IDLE, timeout_err=1, nothing written.
  - CAPT: each beat_valid writes, increments beat_cnt and resets timer. On the beat making beat_cnt==BL/2: commit the burst (committed write pointer = shadow, count += BL), pulse burst_done the next cycle, -> IDLE. Timer expiry -> roll the shadow pointer back to the committed pointer, timeout_err=1, -> IDLE.
  - DROP: counts BL/2 beats without writing, then -> IDLE. Timeout also -> IDLE, with no extra flag.
- Listen in ARMED/CAPT/DROP: ignored, overflow=1. The burst in progress is unaffected.
- Listen to first beat: min 1 cycle. A beat in the same cycle as listen is not captured.
- Read: rd_en & !empty -> dout/dout_valid next cycle (latency 1); count -1. rd_en & empty -> ignored, dout holds, dout_valid=0.
- A commit (+BL) and a pop (-1) in the same cycle yield a net count of +BL-1. empty/full are derived from the registered count.
- Pointers wrap modulo ring size. Count width is clog2(NBURST*BL)+1. Uncommitted words are never visible to the reader.
- clear_err has priority over a same-cycle flag set: the flag clears and the new event is lost.

Optional Feature:
DDR2_RBUF_STATS_EN:
- Defined: stat_bursts increments on each commit; stat_drops increments on each DROP entry or timeout abort. Both are 16-bit saturating and reset to 0.
- Undefined: stat_* are tied to 0 and no counter logic is present.

Decomposition:
- Package ddr2_rbuf_pkg:
  - FSM state enum (IDLE, ARMED, CAPT, DROP)
  - clog2-derived pointer/count width constants
  - legal-BL check constant
- Sub-module ddr2_rbuf_mem: 1-write/1-read register array of 2*DW-bit entries, parametrised on depth; no reset on data.

Test Plan:
- BL=8, NBURST=4: listen, then 4 beats rise/fall = 0x0000..0x0007 -> burst_done once; 8 pops return 0x0000..0x0007 in order; empty=1 after.
- Fill 4 bursts without reading -> full=1; 5th listen -> overflow=1, DROP consumes 4 beats, contents unchanged. Pop one burst, then a new burst commits.
- Listen, 2 beats, stall TIMEOUT cycles -> timeout_err=1, empty stays 1. The next complete burst reads back without stale words.
- Pop every cycle while a burst commits -> count tracks commit/pop (+BL-1); pointer wraps past entry NBURST*BL/2-1 with no data loss over 10 bursts.
- rd_en while empty and listen while CAPT -> no dout_valid; overflow=1. clear_err -> overflow=0.
- reset_n asserted mid-CAPT -> all outputs return to reset values immediately; the post-reset burst is captured correctly.
